ro_edge_meter: RTL and testbench

- Frequency-measurement stage directly downstream of the tile's ring-oscillator / free-running counter output.
- Samples an asynchronous oscillator signal and counts its rising edges over a programmable gate window of clk cycles.
- Holds the count until it is accepted through a valid/ready handshake, so the pin-driver stage can present it on uo_out.

---
 rtl/ro_edge_meter.sv | 155 +++++++++++++++
 tb/tb_ro_edge_meter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_edge_meter.sv
// Ring-oscillator edge meter: counts synchronized rising edges of ro_in over a gate window
// and holds the count behind a valid/ready handshake. Optional prescaler: RO_EDGE_METER_PRESCALE_EN.
module ro_edge_meter #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       gate_len,
    input  logic             ro_in,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        HOLD
    } state_t;

    localparam int ARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic ro_src;

`ifdef RO_EDGE_METER_PRESCALE_EN
    // Divide-by-4 ripple chain runs in the oscillator domain so ro_in may exceed clk/2.
    logic div0_q, div0_d;
    logic div1_q, div1_d;

    assign div0_d = ~div0_q;
    assign div1_d = ~div1_q;

    always_ff @(posedge ro_in or posedge rst) begin
        if (rst) div0_q <= 1'b0;
        else     div0_q <= div0_d;
    end

    always_ff @(negedge div0_q or posedge rst) begin
        if (rst) div1_q <= 1'b0;
        else     div1_q <= div1_d;
    end

    assign ro_src = div1_q;
`else
    assign ro_src = ro_in;
`endif

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   edge_seen;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], ro_src};
    assign hist_d    = sync_q[SYNC_STAGES-1];
    assign edge_seen = sync_q[SYNC_STAGES-1] & ~hist_q;

    state_t           state_q, state_d;
    logic [8:0]       gate_cnt_q, gate_cnt_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d        = state_q;
        gate_cnt_d     = gate_cnt_q;
        arm_cnt_d      = arm_cnt_q;
        count_d        = count_q;
        sat_d          = sat_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        overflow_d     = overflow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ARM;
                    gate_cnt_d = (gate_len == 8'd0) ? 9'd256 : {1'b0, gate_len};
                    arm_cnt_d  = ARM_W'(SYNC_STAGES - 1);
                    count_d    = '0;
                    sat_d      = 1'b0;
                end
            end
            ARM: begin
                if (arm_cnt_q == '0) state_d = MEASURE;
                else                 arm_cnt_d = arm_cnt_q - ARM_W'(1);
            end
            MEASURE: begin
                if (edge_seen) begin
                    if (count_q == CNT_MAX) sat_d = 1'b1;
                    else                    count_d = count_q + CNT_W'(1);
                end
                gate_cnt_d = gate_cnt_q - 9'd1;
                // The final cycle's edge is folded in by forwarding the next-state count.
                if (gate_cnt_q == 9'd1) begin
                    state_d        = HOLD;
                    result_d       = count_d;
                    overflow_d     = sat_d;
                    result_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (result_ready) begin
                    state_d        = IDLE;
                    result_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q         <= '0;
            hist_q         <= 1'b0;
            state_q        <= IDLE;
            gate_cnt_q     <= '0;
            arm_cnt_q      <= '0;
            count_q        <= '0;
            sat_q          <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            hist_q         <= hist_d;
            state_q        <= state_d;
            gate_cnt_q     <= gate_cnt_d;
            arm_cnt_q      <= arm_cnt_d;
            count_q        <= count_d;
            sat_q          <= sat_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overflow_q     <= overflow_d;
            busy_q         <= busy_d;
        end
    end

    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_ro_edge_meter.sv
// Scoreboard bench for ro_edge_meter: an 8-bit and a 4-bit instance share the oscillator stimulus.
// Expected counts also cover the RO_EDGE_METER_PRESCALE_EN build.
module tb_ro_edge_meter;

    typedef struct {
        int res;
        int ovf;
    } exp_t;

`ifdef RO_EDGE_METER_PRESCALE_EN
    localparam int EXP_B = 1, EXP_C4 = 8, EXP_C4_OVF = 0, EXP_D = 8, EXP_E = 8;
`else
    localparam int EXP_B = 4, EXP_C4 = 15, EXP_C4_OVF = 1, EXP_D = 32, EXP_E = 32;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start4;
    logic [7:0] gate_len;
    logic       ro_in = 1'b0;
    logic       result_ready, ready4;
    logic       busy, busy4;
    logic [7:0] result;
    logic [3:0] result4;
    logic       result_valid, valid4;
    logic       overflow, overflow4;

    int   errors = 0;
    int   checks = 0;
    int   ro_period = 0;
    int   ro_level = 0;
    int   ro_phase = 0;
    exp_t exp_q[$];
    exp_t exp4_q[$];

    ro_edge_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .gate_len(gate_len), .ro_in(ro_in),
        .busy(busy), .result(result), .result_valid(result_valid),
        .result_ready(result_ready), .overflow(overflow)
    );

    ro_edge_meter #(.CNT_W(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .gate_len(gate_len), .ro_in(ro_in),
        .busy(busy4), .result(result4), .result_valid(valid4),
        .result_ready(ready4), .overflow(overflow4)
    );

    always #5 clk = ~clk;

    // Oscillator model: a square wave of ro_period clk cycles, or a static level when the period is 0.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (ro_period > 0) begin
                ro_phase = (ro_phase + 1) % ro_period;
                ro_in = (ro_phase < ro_period / 2);
            end else begin
                ro_in = (ro_level != 0);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic popAndCompare(input string tag, input int res, input int ovf, inout exp_t q[$]);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_unexpected: got result %0d, expected no result", tag, res);
        end else begin
            e = q.pop_front();
            checkOutput({tag, "_result"}, res, e.res);
            checkOutput({tag, "_overflow"}, ovf, e.ovf);
        end
    endtask

    // Monitors: compare each accepted result against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready)
            popAndCompare("dut8", int'(result), int'(overflow), exp_q);
    end

    always @(negedge clk) begin
        if (!rst && valid4 && ready4)
            popAndCompare("dut4", int'(result4), int'(overflow4), exp4_q);
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int g, input int exp_res, input int exp_ovf,
                                 input bit push, input bit wait_done);
        exp_t e;
        int   cycles;
        int   busy_ok;
        int   n;
        logic [7:0] g8;
        g8 = g[7:0];
        n = (g8 == 8'd0) ? 256 : int'(g8);
        @(posedge clk);
        #1;
        gate_len = g8;
        start = 1'b1;
        if (push) begin
            e.res = exp_res;
            e.ovf = exp_ovf;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        gate_len = ~g8;
        if (wait_done) begin
            cycles = 1;
            busy_ok = 1;
            while (!result_valid && cycles < 600) begin
                if (!busy) busy_ok = 0;
                @(posedge clk);
                #1;
                cycles++;
            end
            checkOutput("latency", cycles, 3 + n);
            checkOutput("busy_window", busy_ok, 1);
            checkOutput("busy_hold", int'(busy), 1);
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int   stable_ok;
        logic [7:0] held;
        int   cycles;

        rst = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        gate_len = 8'd0;
        result_ready = 1'b1;
        ready4 = 1'b1;

        waitCycles(3);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_result", int'(result), 0);
        checkOutput("rst_valid", int'(result_valid), 0);
        checkOutput("rst_overflow", int'(overflow), 0);
        checkOutput("rst_valid4", int'(valid4), 0);
        rst = 1'b0;

        $display("[TB] ro_in held high, gate 20");
        ro_period = 0;
        ro_level = 1;
        waitCycles(10);
        applyStimulus(20, 0, 0, 1'b1, 1'b1);

        $display("[TB] period 4, gate 16, delayed accept");
        ro_period = 4;
        waitCycles(80);
        result_ready = 1'b0;
        applyStimulus(16, EXP_B, 0, 1'b1, 1'b1);
        held = result;
        stable_ok = 1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!result_valid || result !== held || !busy) stable_ok = 0;
        end
        checkOutput("hold_stable", stable_ok, 1);
        checkOutput("hold_value", int'(held), EXP_B);
        result_ready = 1'b1;
        waitCycles(1);
        checkOutput("accept_valid_drop", int'(result_valid), 0);
        checkOutput("accept_idle", int'(busy), 0);

        $display("[TB] 4-bit instance saturation, period 2, gate 64");
        ro_period = 2;
        waitCycles(80);
        @(posedge clk);
        #1;
        gate_len = 8'd64;
        start4 = 1'b1;
        exp4_q.push_back('{res: EXP_C4, ovf: EXP_C4_OVF});
        @(posedge clk);
        #1;
        start4 = 1'b0;
        cycles = 1;
        while (!valid4 && cycles < 600) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("latency4", cycles, 67);

        $display("[TB] period 2, gate 64, 8-bit instance");
        applyStimulus(64, EXP_D, 0, 1'b1, 1'b1);

        $display("[TB] period 8, gate 0 (256), stray starts");
        ro_period = 8;
        waitCycles(80);
        result_ready = 1'b0;
        applyStimulus(0, EXP_E, 0, 1'b1, 1'b0);
        waitCycles(50);
        start = 1'b1;
        waitCycles(1);
        start = 1'b0;
        cycles = 0;
        while (!result_valid && cycles < 600) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput("stray_latency", cycles, 259 - 52);
        start = 1'b1;
        waitCycles(1);
        result_ready = 1'b1;
        waitCycles(1);
        start = 1'b0;
        waitCycles(20);
        checkOutput("stray_busy", int'(busy), 0);
        checkOutput("stray_valid", int'(result_valid), 0);

        $display("[TB] reset mid-measure");
        ro_period = 2;
        waitCycles(20);
        applyStimulus(64, 0, 0, 1'b0, 1'b0);
        waitCycles(10);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_result", int'(result), 0);
        checkOutput("midrst_valid", int'(result_valid), 0);
        checkOutput("midrst_overflow", int'(overflow), 0);
        waitCycles(2);
        rst = 1'b0;
        waitCycles(20);
        applyStimulus(64, EXP_D, 0, 1'b1, 1'b1);
        waitCycles(5);

        checkOutput("queue8_empty", exp_q.size(), 0);
        checkOutput("queue4_empty", exp4_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
